// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  // System clocks per serial bit.
  function automatic int unsigned clk_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous first-word-fall-through FIFO; head word, count and status flags are registered.
module uart_byte_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   full,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt_c;
  logic             pop_ok_c;
  logic             push_ok_c;
  logic [CNT_W-1:0] count_nxt_c;
  logic [WIDTH-1:0] head_nxt_c;

  // A full FIFO still accepts a push when the head is leaving in the same cycle.
  assign pop_ok_c     = pop && !empty;
  assign push_ok_c    = push && (!full || pop_ok_c);
  assign rd_ptr_nxt_c = rd_ptr + PTR_W'(1);

  always_comb begin
    count_nxt_c = count;
    if (push_ok_c && !pop_ok_c) begin
      count_nxt_c = count + CNT_W'(1);
    end else if (!push_ok_c && pop_ok_c) begin
      count_nxt_c = count - CNT_W'(1);
    end
  end

  // Next head word: the following entry on pop, or the incoming word when it becomes the only entry.
  always_comb begin
    head_nxt_c = pop_data;
    if (pop_ok_c) begin
      head_nxt_c = (count == CNT_W'(1)) ? push_data : mem[rd_ptr_nxt_c];
    end else if (push_ok_c && empty) begin
      head_nxt_c = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      pop_data <= '0;
    end else begin
      if (push_ok_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok_c) begin
        rd_ptr <= rd_ptr_nxt_c;
      end
      count    <= count_nxt_c;
      full     <= (count_nxt_c == CNT_W'(DEPTH));
      empty    <= (count_nxt_c == '0);
      pop_data <= head_nxt_c;
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// Buffered UART receiver: synchroniser, 3-sample majority vote, framing FSM, sticky errors, FWFT FIFO.
// Optional parity stage is built when UART_RX_PARITY_EN is defined.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  input  logic [1:0]                  cfg_parity,
  output logic [DATA_BITS-1:0]        m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun_err,
  input  logic                        err_clr
);

  localparam int unsigned CPB   = clk_per_bit(CLK_HZ, BAUD);
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  logic                 sync1;
  logic                 sync2;
  logic                 prev;
  rx_state_e            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 smp_a;
  logic                 smp_b;
  logic                 stop_bad;
  logic                 par_bad;

  logic vote_c;
  logic at_vote_c;
  logic end_bit_c;
  logic last_stop_c;
  logic par_on_c;
  logic pop_c;
  logic last_vote_c;
  logic good_c;
  logic push_c;
  logic frame_evt_c;
  logic overrun_evt_c;
  logic fifo_full;
  logic fifo_empty;

  // Metastability guard plus the previous-sample flop for start-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign at_vote_c   = (cnt == CNT_W'(HALF + 1));
  assign end_bit_c   = (cnt == CNT_W'(CPB - 1));
  assign vote_c      = (smp_a & smp_b) | (smp_a & sync2) | (smp_b & sync2);
  assign last_stop_c = (stop_idx == 1'(STOP_BITS - 1));

`ifdef UART_RX_PARITY_EN
  logic par_exp_c;
  assign par_on_c  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
  assign par_exp_c = (^shreg) ^ (cfg_parity == PAR_ODD);
`else
  logic unused_cfg;
  assign par_on_c   = 1'b0;
  assign unused_cfg = ^cfg_parity;
`endif

  // Frame outcome is decided on the vote cycle of the last stop bit.
  assign pop_c         = m_valid && m_ready;
  assign last_vote_c   = (state == STOP) && at_vote_c && last_stop_c;
  assign good_c        = last_vote_c && vote_c && !stop_bad && !par_bad;
  assign push_c        = good_c && (!fifo_full || pop_c);
  assign overrun_evt_c = good_c && fifo_full && !pop_c;
  assign frame_evt_c   = (state == STOP) && at_vote_c && !vote_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      smp_a    <= 1'b0;
      smp_b    <= 1'b0;
      stop_bad <= 1'b0;
      par_bad  <= 1'b0;
    end else begin
      if (cnt == CNT_W'(HALF - 1)) begin
        smp_a <= sync2;
      end
      if (cnt == CNT_W'(HALF)) begin
        smp_b <= sync2;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          if (prev && !sync2) begin
            state    <= START;
            busy     <= 1'b1;
            stop_bad <= 1'b0;
            par_bad  <= 1'b0;
          end
        end
        START: begin
          // A start bit that votes high was a glitch: back to IDLE silently.
          if (at_vote_c && vote_c) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (end_bit_c) begin
            state   <= DATA;
            cnt     <= '0;
            bit_idx <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (at_vote_c) begin
            shreg <= {vote_c, shreg[DATA_BITS-1:1]};
          end
          if (end_bit_c) begin
            cnt <= '0;
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              state    <= par_on_c ? PARITY : STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (at_vote_c) begin
            par_bad <= (vote_c != par_exp_c);
          end
          if (end_bit_c) begin
            state <= STOP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          // Leave at the last stop vote so the next start edge is caught half a bit early.
          if (at_vote_c) begin
            if (!vote_c) begin
              stop_bad <= 1'b1;
            end
            if (last_stop_c) begin
              state <= IDLE;
              busy  <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else if (end_bit_c) begin
            cnt      <= '0;
            stop_idx <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Sticky flags: a new event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= frame_evt_c | (frame_err & ~err_clr);
      overrun_err <= overrun_evt_c | (overrun_err & ~err_clr);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= (last_vote_c & par_bad) | (parity_err & ~err_clr);
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign m_valid = !fifo_empty;

  uart_byte_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (shreg),
    .full      (fifo_full),
    .pop       (pop_c),
    .pop_data  (m_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
